// File: rtl/ins_fetch.sv
// Instruction fetch stage: owns the PC, issues one word-aligned read at a time,
// and hands each returned instruction with its PC to decode over valid/ready.
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_kill;
  logic [31:0] r_ins;
  logic [31:0] r_ins_pc;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_nxt;
  logic        w_kill_nxt;
  logic [31:0] w_ins_nxt;
  logic [31:0] w_ins_pc_nxt;
  logic        w_unused_lsbs;

  assign w_unused_lsbs = ^redirect_pc[1:0];

  // Next-state logic; a redirect overrides the sequential PC update below.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_seq     = r_pc;
    w_kill_nxt   = r_kill;
    w_ins_nxt    = r_ins;
    w_ins_pc_nxt = r_ins_pc;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
          // A redirect on the accept edge leaves a stale request in flight.
          w_kill_nxt  = redirect;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (r_kill || redirect) begin
            w_state_nxt = S_REQ;
            w_kill_nxt  = 1'b0;
          end else begin
            w_state_nxt  = S_HOLD;
            w_ins_nxt    = mem_rsp_data;
            w_ins_pc_nxt = r_pc;
            w_pc_seq     = r_pc + 32'd4;
          end
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (ins_ready || redirect) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_pc_nxt = redirect ? {redirect_pc[31:2], 2'b00} : w_pc_seq;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_kill   <= 1'b0;
      r_ins    <= 32'd0;
      r_ins_pc <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_kill   <= w_kill_nxt;
      r_ins    <= w_ins_nxt;
      r_ins_pc <= w_ins_pc_nxt;
    end
  end

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_addr  = r_pc;
  assign ins_valid     = (r_state == S_HOLD);
  assign ins           = r_ins;
  assign ins_pc        = r_ins_pc;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the fetch protocol.
module tb_ins_fetch;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  always #5 clk = ~clk;

  ins_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins           (ins),
    .ins_pc        (ins_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: what the fetch stage owes its neighbours, in transaction terms.
  bit          m_idle;    // just out of reset, no request yet
  bit          m_pend;    // a request is outstanding at memory
  bit          m_kill;    // that outstanding request was superseded by a redirect
  bit          m_hold;    // an instruction is being offered to decode
  logic [31:0] m_pc;      // address of the next fetch
  logic [31:0] m_paddr;   // address of the outstanding request
  logic [31:0] m_ins;
  logic [31:0] m_ins_pc;
  int          m_cnt;     // cycles until memory answers
  int          lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs, drive inputs for the next edge, advance the model.
  task automatic step(input bit rdy, input bit irdy, input bit redir,
                      input logic [31:0] rpc, input bit junk);
    bit rsp;
    chk_eq("mem_req_valid", 32'(mem_req_valid), 32'(!m_idle && !m_pend && !m_hold));
    chk_eq("mem_req_addr", mem_req_addr, m_pc);
    chk_eq("ins_valid", 32'(ins_valid), 32'(m_hold));
    if (m_hold) begin
      chk_eq("ins", ins, m_ins);
      chk_eq("ins_pc", ins_pc, m_ins_pc);
    end
    rsp = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        rsp = 1'b1;
        mem_rsp_data = mem_word(m_paddr);
      end else begin
        m_cnt--;
        mem_rsp_data = $urandom;
      end
    end else begin
      rsp = junk;
      mem_rsp_data = $urandom;
    end
    mem_rsp_valid = rsp;
    mem_req_ready = rdy;
    ins_ready     = irdy;
    redirect      = redir;
    redirect_pc   = rpc;
    if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_pend) begin
      if (rsp) begin
        m_pend = 1'b0;
        if (!(m_kill || redir)) begin
          m_hold   = 1'b1;
          m_ins    = mem_word(m_paddr);
          m_ins_pc = m_paddr;
          m_pc     = m_paddr + 32'd4;
        end
        m_kill = 1'b0;
      end else if (redir) begin
        m_kill = 1'b1;
      end
    end else if (m_hold) begin
      if (irdy || redir) m_hold = 1'b0;
    end else if (rdy) begin
      m_pend  = 1'b1;
      m_paddr = m_pc;
      m_kill  = redir;
      m_cnt   = lat;
    end
    if (redir) m_pc = {rpc[31:2], 2'b00};
    @(negedge clk);
  endtask

  // Async reset, optionally with a memory response arriving while reset is held.
  task automatic hw_reset(input bit inject);
    rst_n         = 1'b0;
    mem_req_ready = 1'b0;
    ins_ready     = 1'b0;
    redirect      = 1'b0;
    mem_rsp_valid = inject;
    mem_rsp_data  = 32'hDEAD_BEEF;
    m_idle = 1'b1; m_pend = 1'b0; m_kill = 1'b0; m_hold = 1'b0;
    m_pc = RST_PC; m_ins = 32'd0; m_ins_pc = 32'd0;
    #1;
    chk_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk_eq("rst_req_addr", mem_req_addr, RST_PC);
    chk_eq("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk_eq("rst_ins", ins, 32'd0);
    chk_eq("rst_ins_pc", ins_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rp;
    #2;
    hw_reset(1'b0);

    // Back-to-back fetches with L=1 across the PC wrap: FFFFFFFC, 0, 4, 8.
    lat = 1;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Decode stall on the instruction at 0x8.
    for (int i = 0; i < 10 && !m_hold; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_eq("reach_hold_stall", 32'(m_hold), 32'd1);
    chk_eq("stall_ins", ins, 32'h0050_0093);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect to 0x103 while waiting on a slow response.
    lat = 4;
    for (int i = 0; i < 10 && !m_pend; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_eq("reach_wait", 32'(m_pend), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect to 0x200 on the same edge the request is accepted.
    lat = 2;
    for (int i = 0; i < 10 && (m_idle || m_pend || m_hold); i++)
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_eq("reach_req", 32'(m_idle || m_pend || m_hold), 32'd0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Redirect to 0x40 while decode is stalled.
    for (int i = 0; i < 10 && !m_hold; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_eq("reach_hold", 32'(m_hold), 32'd1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a wait, with the response landing during reset.
    lat = 3;
    for (int i = 0; i < 10 && !m_pend; i++) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_eq("reach_wait_rst", 32'(m_pend), 32'd1);
    hw_reset(1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);

    // Random traffic: variable latency, stalls, redirects, stray responses.
    for (int n = 0; n < 3000; n++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rp = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        hw_reset(1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 19) == 0, rp, $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch stage of the single-issue RV32I core. Holds the program counter and issues one word-aligned read at a time to the instruction memory port. Presents each returned 32-bit instruction, with its PC, to decode via a valid/ready handshake: `ins[6:0]` drives the immediate-type lookup and `ins[31:7]` drives the immediate generator. Accepts a PC redirect from execute (branch/jump) at any time and discards any stale fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req_valid`  out  1  read request to instruction memory.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_req_addr`  out  32  request byte address, always word-aligned.
- `mem_rsp_valid`  in  1  read data valid; at most one response per accepted request, no earlier than the cycle after acceptance.
- `mem_rsp_data`  in  32  instruction word.
- `ins_valid`  out  1  `ins`/`ins_pc` hold a valid instruction for decode.
- `ins_ready`  in  1  decode consumes the instruction this cycle.
- `ins`  out  32  instruction word.
- `ins_pc`  out  32  address of `ins`.
- `redirect`  in  1  single-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] are forced to 0 on capture.

## Operation
- State machine with states IDLE, REQ, WAIT and HOLD, plus registers `pc`, `kill`, `ins` and `ins_pc`.
- Combinational outputs:
  - `mem_req_valid` = (state==REQ).
  - `mem_req_addr` = `pc`.
  - `ins_valid` = (state==HOLD).
- IDLE: entered only by reset. Goes to REQ on the next edge.
- REQ:
  - Holds `mem_req_valid` high and `mem_req_addr` stable until `mem_req_ready`.
  - On acceptance, goes to WAIT.
- WAIT:
  - Ignores `mem_req_ready`.
  - On `mem_rsp_valid` with `kill`=0: captures `ins`←`mem_rsp_data` and `ins_pc`←`pc`, sets `pc`←`pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), goes to HOLD.
  - On `mem_rsp_valid` with `kill`=1: drops the data, clears `kill`, goes to REQ. `pc` already holds the redirect target.
- HOLD:
  - Holds `ins`/`ins_pc` stable while `ins_ready`=0.
  - On `ins_ready`, goes to REQ.
- `mem_rsp_valid` outside WAIT is ignored.
- Redirect (highest priority; `pc`←{`redirect_pc`[31:2],2'b00} in every state):
  - IDLE: goes to REQ with the new `pc`.
  - REQ without acceptance that cycle: stays in REQ with the new address next cycle.
  - REQ with `mem_req_ready` the same cycle: the old-address request is outstanding. Goes to WAIT with `kill`←1.
  - WAIT: `kill`←1. If `mem_rsp_valid` arrives the same cycle, that response is dropped and the state goes to REQ with `kill`=0.
  - HOLD: goes to REQ and `ins_valid` drops next cycle. If `ins_ready` is also high, decode's consumption stands, but `pc`+4 is not used.
- Back-to-back redirects: the last one wins. `kill` stays set until one response is dropped.

## Timing
- Reset values: state IDLE, `pc`=`RESET_PC`, `kill`=0, `ins`=0, `ins_pc`=0. Hence `mem_req_valid`=0, `mem_req_addr`=`RESET_PC`, `ins_valid`=0.
- Reset asserted mid-operation returns immediately to the reset values. A memory response in flight is then ignored, because the state is not WAIT.
- First `mem_req_valid` is in the 2nd cycle after `rst_n` rises.
- Response latency L≥1 cycles after acceptance. `ins_valid` rises the cycle after `mem_rsp_valid`.
- Best-case throughput (L=1, ready always high): one instruction per 3 cycles, in the sequence REQ, WAIT, HOLD.
- Redirect to new-target request: `mem_req_valid` with the new address is high the next cycle from REQ/HOLD/IDLE. From WAIT, it is high the cycle after the stale response.
- No combinational path from `mem_rsp_*`, `ins_ready` or `redirect` to any output.

## Test plan
- Reset, then memory with L=1, ready=1, `ins_ready`=1: requests at 0x0, 0x4 and 0x8, with `ins_valid` every 3rd cycle. `ins_pc` goes 0, 4, 8 and `ins` matches the data returned.
- Decode stall: hold `ins_ready`=0 for 5 cycles with `ins`=0x00500093. `ins`/`ins_pc` are stable, there is no new request, and one fetch follows acceptance.
- Redirect to 0x103 during WAIT with L=4: the stale response is dropped with no `ins_valid`. Next request is at 0x100 and `ins_pc`=0x100.
- Redirect to 0x200 coincident with `mem_req_ready` in REQ: exactly one response is dropped, then the request goes to 0x200.
- Redirect to 0x40 in HOLD with `ins_ready`=0: `ins_valid` drops next cycle and the request goes to 0x40.
- PC wrap: `RESET_PC`=0xFFFF_FFFC gives requests at 0xFFFF_FFFC then 0x0. Pulling `rst_n` low in WAIT and injecting a response gives no `ins_valid` and a first request at `RESET_PC`.
